// File: rtl/vga_pkg.sv
// Shared VGA constants: default 640x480@60 timing, TinyVGA PMOD bit positions,
// the 2-2-2 colour type and a bit-width helper for counter sizing.
package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  // TinyVGA PMOD byte: {hsync, b0, g0, r0, vsync, b1, g1, r1}
  localparam int PMOD_HS = 7;
  localparam int PMOD_B0 = 6;
  localparam int PMOD_G0 = 5;
  localparam int PMOD_R0 = 4;
  localparam int PMOD_VS = 3;
  localparam int PMOD_B1 = 2;
  localparam int PMOD_G1 = 1;
  localparam int PMOD_R1 = 0;

  typedef struct packed {
    logic [1:0] r;
    logic [1:0] g;
    logic [1:0] b;
  } rgb222_t;

  // Bits needed to hold values 0..max_val (never less than 1).
  function automatic int width_for(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Generic WIDTH x DEPTH shift register, loaded with rst_val on synchronous
// active-low reset; DEPTH=0 collapses to a wire.
module vga_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             sys_rst,
  input  logic [WIDTH-1:0] rst_val,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic unused_ok;
      assign unused_ok = ^{clk, sys_rst, rst_val};
      assign dout      = din;
    end else begin : g_pipe
      logic [WIDTH-1:0] stage [DEPTH];

      always_ff @(posedge clk) begin
        if (!sys_rst) begin
          for (int i = 0; i < DEPTH; i++) stage[i] <= rst_val;
        end else begin
          stage[0] <= din;
          for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign dout = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_pmod.sv
// Parametrised VGA timing generator with syncs aligned to the render pipeline and a
// registered TinyVGA PMOD byte. Define VGA_FRAME_CNT_EN to add the frame_cnt output.
module vga_timing_pmod
  import vga_pkg::*;
#(
  parameter int H_ACTIVE    = H_ACTIVE_DEF,
  parameter int H_FP        = H_FP_DEF,
  parameter int H_SYNC      = H_SYNC_DEF,
  parameter int H_BP        = H_BP_DEF,
  parameter int V_ACTIVE    = V_ACTIVE_DEF,
  parameter int V_FP        = V_FP_DEF,
  parameter int V_SYNC      = V_SYNC_DEF,
  parameter int V_BP        = V_BP_DEF,
  parameter int HSYNC_POL   = 0,
  parameter int VSYNC_POL   = 0,
  parameter int ADDR_W      = 10,
  parameter int PIX_DIV     = 1,
  parameter int COLOR_DELAY = 1
) (
  input  logic              clk,
  input  logic              sys_rst,
  input  logic [5:0]        rgb_in,
  output logic [ADDR_W-1:0] haddr,
  output logic [ADDR_W-1:0] vaddr,
  output logic              display_on,
  output logic              pix_en,
  output logic              line_start,
  output logic              frame_start,
  output logic [7:0]        vga_pmod
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [7:0]        frame_cnt
`endif
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam int DIV_W    = width_for(PIX_DIV - 1);

  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(PIX_DIV - 1);
  localparam logic [ADDR_W-1:0] H_LAST   = ADDR_W'(H_TOTAL - 1);
  localparam logic [ADDR_W-1:0] V_LAST   = ADDR_W'(V_TOTAL - 1);
  localparam logic              HS_ON    = 1'(HSYNC_POL);
  localparam logic              VS_ON    = 1'(VSYNC_POL);

  generate
    if (!(PIX_DIV == 1 || PIX_DIV == 2 || PIX_DIV == 4)) begin : g_bad_div
      $error("vga_timing_pmod: PIX_DIV must be 1, 2 or 4");
    end
    if (COLOR_DELAY < 0 || COLOR_DELAY > 4) begin : g_bad_delay
      $error("vga_timing_pmod: COLOR_DELAY must be in 0..4");
    end
    if (ADDR_W < width_for(H_TOTAL - 1) || ADDR_W < width_for(V_TOTAL - 1)) begin : g_bad_addr
      $error("vga_timing_pmod: ADDR_W too narrow for H_TOTAL/V_TOTAL");
    end
  endgenerate

  logic [DIV_W-1:0] div_cnt;
  logic             h_last;
  logic             v_last;
  logic             hs_raw;
  logic             vs_raw;
  logic             hs;
  logic             vs;
  logic [2:0]       align_q;
  logic             hs_d;
  logic             vs_d;
  logic             de_d;
  rgb222_t          px;
  logic [7:0]       pmod_next;

  assign pix_en      = (div_cnt == DIV_LAST) && sys_rst;
  assign h_last      = (haddr == H_LAST);
  assign v_last      = (vaddr == V_LAST);
  assign line_start  = pix_en && (haddr == '0);
  assign frame_start = line_start && (vaddr == '0);

  always_ff @(posedge clk) begin
    if (!sys_rst) begin
      div_cnt <= '0;
      haddr   <= '0;
      vaddr   <= '0;
    end else begin
      div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
      if (pix_en) begin
        if (h_last) begin
          haddr <= '0;
          vaddr <= v_last ? '0 : vaddr + 1'b1;
        end else begin
          haddr <= haddr + 1'b1;
        end
      end
    end
  end

  assign display_on = (32'(haddr) < H_ACTIVE) && (32'(vaddr) < V_ACTIVE);
  assign hs_raw     = (32'(haddr) >= HS_START) && (32'(haddr) < HS_END);
  assign vs_raw     = (32'(vaddr) >= VS_START) && (32'(vaddr) < VS_END);
  assign hs         = hs_raw ? HS_ON : ~HS_ON;
  assign vs         = vs_raw ? VS_ON : ~VS_ON;

  // Syncs and blanking ride alongside the render pipeline so they meet rgb_in together.
  vga_delay_line #(
    .WIDTH (3),
    .DEPTH (COLOR_DELAY)
  ) u_align (
    .clk     (clk),
    .sys_rst (sys_rst),
    .rst_val ({~HS_ON, ~VS_ON, 1'b0}),
    .din     ({hs, vs, display_on}),
    .dout    (align_q)
  );

  assign {hs_d, vs_d, de_d} = align_q;
  assign px = rgb_in;

  always_comb begin
    pmod_next          = '0;
    pmod_next[PMOD_HS] = hs_d;
    pmod_next[PMOD_VS] = vs_d;
    if (de_d) begin
      pmod_next[PMOD_R0] = px.r[0];
      pmod_next[PMOD_G0] = px.g[0];
      pmod_next[PMOD_B0] = px.b[0];
      pmod_next[PMOD_R1] = px.r[1];
      pmod_next[PMOD_G1] = px.g[1];
      pmod_next[PMOD_B1] = px.b[1];
    end
  end

  always_ff @(posedge clk) begin
    if (!sys_rst) begin
      vga_pmod          <= '0;
      vga_pmod[PMOD_HS] <= ~HS_ON;
      vga_pmod[PMOD_VS] <= ~VS_ON;
    end else begin
      vga_pmod <= pmod_next;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  always_ff @(posedge clk) begin
    if (!sys_rst) begin
      frame_cnt <= '0;
    end else if (pix_en && h_last && v_last) begin
      frame_cnt <= frame_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_pmod.sv
// Directed bench for vga_timing_pmod: four instances (default timing with delay 0 and 2,
// small timing with PIX_DIV 2 and 1) driven from one clock and one reset.
module tb_vga_timing_pmod;

  localparam int N_RUN = 21605;

  logic clk = 1'b0;
  logic sys_rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [5:0] def_rgb, cd2_rgb, pd2_rgb, sm_rgb;
  logic [9:0] def_h, def_v, cd2_h, cd2_v;
  logic [3:0] pd2_h, pd2_v, sm_h, sm_v;
  logic def_disp, def_pix, def_ls, def_fs;
  logic cd2_disp, cd2_pix, cd2_ls, cd2_fs;
  logic pd2_disp, pd2_pix, pd2_ls, pd2_fs;
  logic sm_disp, sm_pix, sm_ls, sm_fs;
  logic [7:0] def_pmod, cd2_pmod, pd2_pmod, sm_pmod;
`ifdef VGA_FRAME_CNT_EN
  logic [7:0] def_fc, cd2_fc, pd2_fc, sm_fc;
`endif

  vga_timing_pmod #(.COLOR_DELAY(0)) u_def (
    .clk(clk), .sys_rst(sys_rst), .rgb_in(def_rgb), .haddr(def_h), .vaddr(def_v),
    .display_on(def_disp), .pix_en(def_pix), .line_start(def_ls), .frame_start(def_fs),
    .vga_pmod(def_pmod)
`ifdef VGA_FRAME_CNT_EN
    , .frame_cnt(def_fc)
`endif
  );

  vga_timing_pmod #(.COLOR_DELAY(2)) u_cd2 (
    .clk(clk), .sys_rst(sys_rst), .rgb_in(cd2_rgb), .haddr(cd2_h), .vaddr(cd2_v),
    .display_on(cd2_disp), .pix_en(cd2_pix), .line_start(cd2_ls), .frame_start(cd2_fs),
    .vga_pmod(cd2_pmod)
`ifdef VGA_FRAME_CNT_EN
    , .frame_cnt(cd2_fc)
`endif
  );

  vga_timing_pmod #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1), .V_ACTIVE(4), .V_FP(1), .V_SYNC(1),
    .V_BP(1), .ADDR_W(4), .PIX_DIV(2), .COLOR_DELAY(1)
  ) u_pd2 (
    .clk(clk), .sys_rst(sys_rst), .rgb_in(pd2_rgb), .haddr(pd2_h), .vaddr(pd2_v),
    .display_on(pd2_disp), .pix_en(pd2_pix), .line_start(pd2_ls), .frame_start(pd2_fs),
    .vga_pmod(pd2_pmod)
`ifdef VGA_FRAME_CNT_EN
    , .frame_cnt(pd2_fc)
`endif
  );

  vga_timing_pmod #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1), .V_ACTIVE(4), .V_FP(1), .V_SYNC(1),
    .V_BP(1), .ADDR_W(4), .PIX_DIV(1), .COLOR_DELAY(0)
  ) u_sm (
    .clk(clk), .sys_rst(sys_rst), .rgb_in(sm_rgb), .haddr(sm_h), .vaddr(sm_v),
    .display_on(sm_disp), .pix_en(sm_pix), .line_start(sm_ls), .frame_start(sm_fs),
    .vga_pmod(sm_pmod)
`ifdef VGA_FRAME_CNT_EN
    , .frame_cnt(sm_fc)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected PMOD byte for the counter state of clock m after reset release (m<0: idle).
  function automatic logic [7:0] pmod_model(input int m, input int div, input int ha,
                                            input int hf, input int hsw, input int hb,
                                            input int va, input int vf, input int vsw,
                                            input int vb, input logic [5:0] rgb);
    int ht, vt, p, h, v;
    logic hs, vs;
    logic [7:0] r;
    if (m < 0) return 8'h88;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    p  = m / div;
    h  = p % ht;
    v  = (p / ht) % vt;
    hs = !(h >= ha + hf && h < ha + hf + hsw);
    vs = !(v >= va + vf && v < va + vf + vsw);
    r  = {hs, 3'b000, vs, 3'b000};
    if (h < ha && v < va) begin
      r[6] = rgb[0]; r[5] = rgb[2]; r[4] = rgb[4];
      r[2] = rgb[1]; r[1] = rgb[3]; r[0] = rgb[5];
    end
    return r;
  endfunction

  initial begin
    int e_cnt, e_pix, e_def, e_cd2, e_pd2, e_sm, ls_count;
    logic [7:0] cd2_after [4];
    e_cnt = 0; e_pix = 0; e_def = 0; e_cd2 = 0; e_pd2 = 0; e_sm = 0; ls_count = 0;
    cd2_after[0] = 8'h88; cd2_after[1] = 8'h88; cd2_after[2] = 8'h88; cd2_after[3] = 8'hFF;
    def_rgb = 6'h26; cd2_rgb = 6'h3F; pd2_rgb = 6'h3F; sm_rgb = 6'h3F;

    sys_rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_haddr", 32'(def_h), 0);
    check_eq("rst_vaddr", 32'(def_v), 0);
    check_eq("rst_pmod", 32'(def_pmod), 32'h88);
    check_eq("rst_pmod_cd2", 32'(cd2_pmod), 32'h88);
    check_eq("rst_pix_en", 32'(def_pix), 0);
    check_eq("rst_frame_start", 32'(sm_fs), 0);
`ifdef VGA_FRAME_CNT_EN
    check_eq("rst_frame_cnt", 32'(sm_fc), 0);
`endif

    sys_rst = 1'b1;
    #1;
    for (int n = 0; n < N_RUN; n++) begin
      int hd, vd, pp, ph, pv, sh, sv;
      hd = n % 800;       vd = n / 800;
      pp = n / 2;         ph = pp % 12;      pv = (pp / 12) % 7;
      sh = n % 12;        sv = (n / 12) % 7;

      if (32'(def_h) != hd || 32'(def_v) != vd) e_cnt++;
      if (32'(cd2_h) != hd || 32'(cd2_v) != vd) e_cnt++;
      if (32'(pd2_h) != ph || 32'(pd2_v) != pv) e_cnt++;
      if (32'(sm_h) != sh || 32'(sm_v) != sv) e_cnt++;

      if (def_pix !== 1'b1 || def_ls !== (hd == 0) || def_fs !== (hd == 0 && vd == 0)) e_pix++;
      if (def_disp !== (hd < 640 && vd < 480) || cd2_disp !== def_disp) e_pix++;
      if (cd2_pix !== 1'b1 || cd2_ls !== def_ls || cd2_fs !== def_fs) e_pix++;
      if (pd2_pix !== (n % 2 == 1) || pd2_ls !== (n % 2 == 1 && ph == 0)) e_pix++;
      if (pd2_fs !== (n % 2 == 1 && ph == 0 && pv == 0) || pd2_disp !== (ph < 8 && pv < 4)) e_pix++;
      if (sm_pix !== 1'b1 || sm_ls !== (sh == 0) || sm_fs !== (n % 84 == 0)) e_pix++;
      if (sm_disp !== (sh < 8 && sv < 4)) e_pix++;
      if (def_ls === 1'b1) ls_count++;

      if (def_pmod !== pmod_model(n - 1, 1, 640, 16, 96, 48, 480, 10, 2, 33, def_rgb)) e_def++;
      if (cd2_pmod !== pmod_model(n - 3, 1, 640, 16, 96, 48, 480, 10, 2, 33, cd2_rgb)) e_cd2++;
      if (pd2_pmod !== pmod_model(n - 2, 2, 8, 1, 2, 1, 4, 1, 1, 1, pd2_rgb)) e_pd2++;
      if (sm_pmod !== pmod_model(n - 1, 1, 8, 1, 2, 1, 4, 1, 1, 1, sm_rgb)) e_sm++;

      if (n == 0) begin
        check_eq("first_frame_start", 32'(def_fs), 1);
        check_eq("first_pix_en", 32'(def_pix), 1);
        check_eq("pd2_pix_en_n0", 32'(pd2_pix), 0);
      end
      if (n == 1) begin
        check_eq("def_pmod_visible", 32'(def_pmod), 32'hAD);
        check_eq("pd2_pix_en_n1", 32'(pd2_pix), 1);
        check_eq("pd2_frame_start_n1", 32'(pd2_fs), 1);
        check_eq("pd2_haddr_hold", 32'(pd2_h), 0);
      end
      if (n == 2) check_eq("pd2_haddr_step", 32'(pd2_h), 1);
      if (n == 641) check_eq("def_pmod_blank", 32'(def_pmod), 32'h88);
      if (n == 656) check_eq("hsync_before", 32'(def_pmod[7]), 1);
      if (n == 657) check_eq("hsync_first", 32'(def_pmod), 32'h08);
      if (n == 752) check_eq("hsync_last", 32'(def_pmod[7]), 0);
      if (n == 753) check_eq("hsync_after", 32'(def_pmod[7]), 1);
      if (n == 800) begin
        check_eq("line2_start", 32'(def_ls), 1);
        check_eq("line2_vaddr", 32'(def_v), 1);
      end
      if (n == 642) check_eq("cd2_last_visible", 32'(cd2_pmod), 32'hFF);
      if (n == 643) check_eq("cd2_first_blank", 32'(cd2_pmod), 32'h88);
      if (n == 658) check_eq("cd2_hsync_before", 32'(cd2_pmod), 32'h88);
      if (n == 659) check_eq("cd2_hsync_first", 32'(cd2_pmod), 32'h08);
      if (n == 23) check_eq("pd2_h_end", 32'(pd2_h), 11);
      if (n == 24) check_eq("pd2_v_step", 32'(pd2_v), 1);
      if (n == 168) check_eq("pd2_wrap_fs_wait", 32'(pd2_fs), 0);
      if (n == 169) check_eq("pd2_wrap_fs", 32'(pd2_fs), 1);
      if (n == 83) check_eq("sm_last_pos", 32'({sm_v, sm_h}), 32'h6B);
      if (n == 84) begin
        check_eq("sm_wrap_pos", 32'({sm_v, sm_h}), 0);
        check_eq("sm_wrap_fs", 32'(sm_fs), 1);
      end
      if (n == 60) check_eq("vsync_before", 32'(sm_pmod[3]), 1);
      if (n == 61) check_eq("vsync_first", 32'(sm_pmod[3]), 0);
      if (n == 72) check_eq("vsync_last", 32'(sm_pmod[3]), 0);
      if (n == 73) check_eq("vsync_after", 32'(sm_pmod[3]), 1);
`ifdef VGA_FRAME_CNT_EN
      if (32'(sm_fc) != (n / 84) % 256) e_cnt++;
      if (n == 84) check_eq("fc_first_inc", 32'(sm_fc), 1);
      if (n == 21503) check_eq("fc_255", 32'(sm_fc), 255);
      if (n == 21504) check_eq("fc_wrap", 32'(sm_fc), 0);
`endif
      @(negedge clk);
    end

    check_eq("counters_scan", e_cnt, 0);
    check_eq("strobes_scan", e_pix, 0);
    check_eq("def_pmod_scan", e_def, 0);
    check_eq("cd2_pmod_scan", e_cd2, 0);
    check_eq("pd2_pmod_scan", e_pd2, 0);
    check_eq("sm_pmod_scan", e_sm, 0);
    check_eq("line_start_count", ls_count, 28);

    // Mid-frame reset: def at haddr 5 line 27, sm at haddr 5 line 1.
    sys_rst = 1'b0;
    #1;
    check_eq("midrst_pix_gated", 32'({def_pix, def_ls, def_fs, sm_pix}), 0);
    check_eq("midrst_hold_until_edge", 32'(sm_h), 5);
    @(negedge clk);
    check_eq("midrst_def_pos", 32'({def_v, def_h}), 0);
    check_eq("midrst_sm_pos", 32'({sm_v, sm_h}), 0);
    check_eq("midrst_pd2_pos", 32'({pd2_v, pd2_h}), 0);
    check_eq("midrst_def_pmod", 32'(def_pmod), 32'h88);
    check_eq("midrst_cd2_pmod", 32'(cd2_pmod), 32'h88);
`ifdef VGA_FRAME_CNT_EN
    check_eq("midrst_frame_cnt", 32'(sm_fc), 0);
`endif
    @(negedge clk);
    sys_rst = 1'b1;
    #1;
    check_eq("midrst_release_fs", 32'(def_fs), 1);
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("cd2_flush_%0d", k), 32'(cd2_pmod), 32'(cd2_after[k]));
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_pmod.md
Name: vga_timing_pmod

Overview:
- Parametrised VGA timing generator and TinyVGA PMOD output stage; successor to the fixed 640x480 `vga` timing block.
- Produces pixel coordinates for the game/render logic and accepts 6-bit colour back from it.
- Delays sync and blank to match the render pipeline latency, then registers the packed 8-bit PMOD byte.
- Sits between the game core (crossyroad render logic) and the `uo_out` pins.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- HSYNC_POL, 0, active level of hsync
- VSYNC_POL, 0, active level of vsync
- ADDR_W, 10, width of haddr/vaddr
- PIX_DIV, 1, clocks per pixel; legal values 1, 2, 4
- COLOR_DELAY, 1, clk cycles from haddr/vaddr to valid rgb_in; legal range 0..4

Ports:
- clk  in  1  system clock
- sys_rst  in  1  synchronous, active-low reset
- rgb_in  in  6  {r[1:0], g[1:0], b[1:0]} for coordinates presented COLOR_DELAY cycles earlier
- haddr  out  ADDR_W  horizontal count, 0..H_TOTAL-1 (H_TOTAL = sum of H params)
- vaddr  out  ADDR_W  vertical count, 0..V_TOTAL-1
- display_on  out  1  haddr<H_ACTIVE && vaddr<V_ACTIVE (undelayed)
- pix_en  out  1  pixel-advance strobe
- line_start  out  1  pix_en && haddr==0
- frame_start  out  1  pix_en && haddr==0 && vaddr==0
- vga_pmod  out  8  registered {hsync, b[0], g[0], r[0], vsync, b[1], g[1], r[1]}

Behaviour:
- Divider: div_cnt counts 0..PIX_DIV-1 every clk. pix_en = (div_cnt==PIX_DIV-1) && sys_rst.
- Counters: haddr and vaddr are registers and advance only on pix_en.
  - haddr==H_TOTAL-1 wraps to 0 and increments vaddr.
  - vaddr==V_TOTAL-1 together with a haddr wrap returns to 0.
- Decode (combinational from counters):
  - hs_raw active for haddr in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - vs_raw active for vaddr in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
  - Active level of each sync is set by HSYNC_POL/VSYNC_POL.
- Alignment: {hs, vs, display_on} pass through a COLOR_DELAY-deep shift register clocked every clk, not gated by pix_en. COLOR_DELAY=0 means a straight wire.
- Output: vga_pmod registered every clk from the delayed syncs and rgb_in AND delayed display_on. Colour bits are forced 0 in blanking.
- Latency: counter value to vga_pmod is COLOR_DELAY+1 clk.
- Reset (sys_rst low at a clk edge):
  - div_cnt, haddr, vaddr = 0.
  - Delay line filled with inactive syncs and display_on=0.
  - vga_pmod = inactive syncs with all colour bits 0.
  - pix_en, line_start, frame_start = 0 while reset is low.
- First pix_en after reset release gives frame_start=1 (haddr=vaddr=0).
- Reset mid-frame takes effect on the next edge; no partial-line completion.
- Illegal PIX_DIV, COLOR_DELAY, or ADDR_W too small for H_TOTAL-1 / V_TOTAL-1: elaboration-time error.

Optional Feature:
- Macro: VGA_FRAME_CNT_EN
- Defined:
  - Adds output frame_cnt[7:0].
  - Reset value 0.
  - Increments on the same pix_en as the vaddr/haddr wrap to 0,0; wraps 255 to 0.
  - frame_start for frame N is asserted in the cycle frame_cnt first shows N.
- Undefined: port and register absent; all other behaviour identical.

Decomposition:
- Package vga_pkg:
  - default 640x480@60 timing constants
  - PMOD bit-index constants (HS=7, VS=3, etc.)
  - rgb222 typedef
  - clog2-based width helper
- One sub-module, vga_delay_line: parametrised width/depth shift register with reset value input; also reused by the render pipeline.

Test Plan:
- Reset: sys_rst=0 for 3 clk, defaults → haddr=vaddr=0, vga_pmod=8'b1000_1000, pix_en=0; after release frame_start=1 on first cycle.
- Horizontal timing (defaults, COLOR_DELAY=0, PIX_DIV=1) → vga_pmod[7]=0 exactly for haddr 656..751, seen one clk later; 800 clk per line; line_start every 800 clk.
- Frame wrap: run to vaddr=524, haddr=799 → next pix_en gives 0,0 with frame_start=1; vga_pmod[3]=0 only for vaddr 490..491.
- Blanking and alignment, COLOR_DELAY=2:
  - Stimulus: model returns rgb_in=6'h3F two clk after haddr<640, and 6'h3F also in blanking.
  - Required: colour bits all 1 for visible pixels, 0 from haddr 640 onward, syncs aligned with colour.
- PIX_DIV=2, small timing (H 8/1/2/1, V 4/1/1/1) → pix_en every 2nd clk, haddr holds 2 clk; H_TOTAL=12, V_TOTAL=7 wrap correct.
- Mid-frame reset at haddr=300, vaddr=200 → next clk counters 0, pmod inactive; VGA_FRAME_CNT_EN build: frame_cnt 255→0 wrap, and cleared by reset.
